// File: rtl/dram_pkg.sv
// dram_pkg: shared states, pin command encodings and address fields
// for the single-port DRAM controller.
package dram_pkg;

  localparam int ROW_W = 11;
  localparam int COL_W = 10;
  localparam int A_W   = 11;
  localparam int WA_W  = ROW_W + COL_W;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACT,
    COL,
    RDWAIT,
    WRWAIT,
    DONE
  } dram_state_t;

  typedef struct packed {
    logic       csn;
    logic       rasn;
    logic       casn;
    logic [3:0] wen;
  } dram_cmd_t;

  localparam dram_cmd_t CMD_RESET =
    '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_IDLE =
    '{csn: 1'b0, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_ACT =
    '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_READ =
    '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};
  localparam dram_cmd_t CMD_WRITE =
    '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'h0};
  localparam dram_cmd_t CMD_PRE =
    '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};

  function automatic logic [A_W-1:0] row_of(
    input logic [WA_W-1:0] wa
  );
    return wa[WA_W-1:COL_W];
  endfunction

  function automatic logic [A_W-1:0] col_of(
    input logic [WA_W-1:0] wa
  );
    return {1'b0, wa[COL_W-1:0]};
  endfunction

endpackage

// File: rtl/dram_delay_cnt.sv
// dram_delay_cnt: loadable 3-bit down-counter; done while at zero.
// Shared by the precharge, activate and write-recovery waits.
module dram_delay_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       done
);

  logic [2:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 3'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign done = (cnt_q == 3'd0);

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-port DRAM controller, one word request at a time.
// Define DRAM_OPEN_PAGE_EN to keep rows open (row-hit path).
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int T_RP  = 5,
  parameter int T_RCD = 5,
  parameter int T_WR  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_VALID
);

  localparam logic [2:0] RP_LD  = 3'(T_RP - 1);
  localparam logic [2:0] RCD_LD = 3'(T_RCD - 1);
  localparam logic [2:0] WR_LD  = 3'(T_WR - 1);

  dram_state_t state_q, state_d;
  logic        wait_q, wait_d;
  logic        wr_q;
  logic [WA_W-1:0] wa_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic            idle;
  logic [WA_W-1:0] cur_wa;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_wstrb;
  logic            lat_en;
  logic            rdata_en;
  logic            cnt_load;
  logic [2:0]      cnt_val;
  logic            cnt_done;

  dram_cmd_t   cmd_q, cmd_d;
  logic [10:0] a_q, a_d;
  logic [31:0] d_q, d_d;
  logic [31:0] rdata_q;

  logic unused_addr;
  assign unused_addr = ^{req_addr[31:23], req_addr[1:0]};

  // Commands are issued on entry, so the IDLE cycle of a
  // handshake uses the live request fields.
  assign idle      = (state_q == IDLE);
  assign cur_wa    = idle ? req_addr[22:2] : wa_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;
  assign cur_wstrb = idle ? req_wstrb : wstrb_q;

`ifdef DRAM_OPEN_PAGE_EN
  logic        row_open_q;
  logic [10:0] open_row_q;
  logic        row_hit;

  assign row_hit = row_open_q &&
    (open_row_q == row_of(req_addr[22:2]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_open_q <= 1'b0;
      open_row_q <= '0;
    end else if (state_d != state_q) begin
      if (state_d == PRE) begin
        row_open_q <= 1'b0;
      end else if (state_d == ACT) begin
        row_open_q <= 1'b1;
        open_row_q <= row_of(cur_wa);
      end
    end
  end
`endif

  dram_delay_cnt u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = 1'b0;
    lat_en   = 1'b0;
    rdata_en = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = 3'd0;
    cmd_d    = CMD_IDLE;
    a_d      = '0;
    d_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_en = 1'b1;
`ifdef DRAM_OPEN_PAGE_EN
          if (!row_open_q) state_d = ACT;
          else if (row_hit) state_d = COL;
          else state_d = PRE;
`else
          state_d = ACT;
`endif
        end
      end
      PRE: begin
        if (!wait_q) begin
          cnt_load = 1'b1;
          cnt_val  = RP_LD;
          wait_d   = 1'b1;
        end else if (cnt_done) begin
`ifdef DRAM_OPEN_PAGE_EN
          state_d = ACT;
`else
          state_d = IDLE;
`endif
        end else begin
          wait_d = 1'b1;
        end
      end
      ACT: begin
        if (!wait_q) begin
          cnt_load = 1'b1;
          cnt_val  = RCD_LD;
          wait_d   = 1'b1;
        end else if (cnt_done) begin
          state_d = COL;
        end else begin
          wait_d = 1'b1;
        end
      end
      COL: begin
        if (wr_q) begin
          state_d  = WRWAIT;
          cnt_load = 1'b1;
          cnt_val  = WR_LD;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (DRAM_VALID) begin
          rdata_en = 1'b1;
          state_d  = DONE;
        end
      end
      WRWAIT: begin
        if (cnt_done) state_d = DONE;
      end
      DONE: begin
`ifdef DRAM_OPEN_PAGE_EN
        state_d = IDLE;
`else
        state_d = PRE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      unique case (1'b1)
        state_d == PRE: cmd_d = CMD_PRE;
        state_d == ACT: begin
          cmd_d = CMD_ACT;
          a_d   = row_of(cur_wa);
        end
        state_d == COL: begin
          a_d = col_of(cur_wa);
          if (idle ? req_write : wr_q) begin
            cmd_d     = CMD_WRITE;
            cmd_d.wen = ~cur_wstrb;
            d_d       = cur_wdata;
          end else begin
            cmd_d = CMD_READ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      wr_q    <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cmd_q   <= CMD_RESET;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      d_q     <= d_d;
      if (lat_en) begin
        wr_q    <= req_write;
        wa_q    <= req_addr[22:2];
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (rdata_en) rdata_q <= DRAM_Q;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign DRAM_CSn  = cmd_q.csn;
  assign DRAM_RASn = cmd_q.rasn;
  assign DRAM_CASn = cmd_q.casn;
  assign DRAM_WEn  = cmd_q.wen;
  assign DRAM_A    = a_q;
  assign DRAM_D    = d_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed bench for dram_ctrl with a small DRAM model.
// Expectations follow DRAM_OPEN_PAGE_EN when it is defined.
module tb_dram_ctrl;

  localparam int T_RP   = 3;
  localparam int T_RCD  = 4;
  localparam int T_WR   = 2;
  localparam int L_DRAM = 3;

`ifdef DRAM_OPEN_PAGE_EN
  localparam bit OPEN = 1'b1;
`else
  localparam bit OPEN = 1'b0;
`endif

  // Hand-derived latencies for the parameters above.
  localparam int LAT_RD_EMPTY = 10;
  localparam int LAT_RD_MISS  = 14;
  localparam int LAT_RD_HIT   = 5;
  localparam int LAT_WR_EMPTY = 9;
  localparam int LAT_WR_MISS  = 13;
  localparam int LAT_WR_HIT   = 4;

  localparam int K_NONE = 0;
  localparam int K_ACT  = 1;
  localparam int K_RD   = 2;
  localparam int K_WR   = 3;
  localparam int K_PRE  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q = '0;
  logic        DRAM_VALID = 1'b0;

  dram_ctrl #(
    .T_RP  (T_RP),
    .T_RCD (T_RCD),
    .T_WR  (T_WR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .DRAM_CSn   (DRAM_CSn),
    .DRAM_RASn  (DRAM_RASn),
    .DRAM_CASn  (DRAM_CASn),
    .DRAM_WEn   (DRAM_WEn),
    .DRAM_A     (DRAM_A),
    .DRAM_D     (DRAM_D),
    .DRAM_Q     (DRAM_Q),
    .DRAM_VALID (DRAM_VALID)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [10:0] a;
    logic [3:0]  wen;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  ev_t         evq[$];
  ev_t         mon_e;
  logic [31:0] mem [int];
  logic [10:0] mrow = '0;
  int          rd_pend = 0;
  logic [31:0] rd_data = '0;
  logic [31:0] mw;

  function automatic int mkey(input logic [10:0] r, input logic [10:0] c);
    return int'({10'd0, r, c});
  endfunction

  function automatic ev_t ev_at(input int i);
    ev_t e;
    e.kind = K_NONE;
    e.a = '0;
    e.wen = '0;
    e.d = '0;
    e.cyc = -1;
    if (i >= 0 && i < evq.size()) e = evq[i];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor and DRAM model, sampled mid-cycle.
  always @(negedge clk) begin
    if (DRAM_VALID) DRAM_VALID = 1'b0;
    if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) begin
        DRAM_VALID = 1'b1;
        DRAM_Q = rd_data;
      end
    end
    if (rst && !DRAM_CSn) begin
      mon_e.kind = K_NONE;
      mon_e.a = DRAM_A;
      mon_e.wen = DRAM_WEn;
      mon_e.d = DRAM_D;
      mon_e.cyc = cyc;
      if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) begin
        mon_e.kind = K_ACT;
        mrow = DRAM_A;
      end else if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0) begin
        mon_e.kind = K_PRE;
      end else if (DRAM_RASn && !DRAM_CASn) begin
        if (DRAM_WEn == 4'hF) begin
          mon_e.kind = K_RD;
          rd_pend = L_DRAM;
          rd_data = mem.exists(mkey(mrow, DRAM_A)) ?
            mem[mkey(mrow, DRAM_A)] : 32'h0;
        end else begin
          mon_e.kind = K_WR;
          mw = mem.exists(mkey(mrow, DRAM_A)) ?
            mem[mkey(mrow, DRAM_A)] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (!DRAM_WEn[b]) mw[8*b +: 8] = DRAM_D[8*b +: 8];
          mem[mkey(mrow, DRAM_A)] = mw;
        end
      end
      if (mon_e.kind != K_NONE) evq.push_back(mon_e);
    end
    if (rsp_valid) chk("rsp_with_ready", req_ready, 1'b0);
  end

  int          hs_cyc, rsp_cyc, ev_base;
  logic [31:0] got_rdata;

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    bit ok = 1'b0;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    chk("hs_timeout", ok, 1'b1);
    hs_cyc = cyc;
    ev_base = evq.size();
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    chk("rsp_timeout", ok, 1'b1);
    rsp_cyc = cyc;
    got_rdata = rsp_rdata;
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 1'b0);
  endtask

  ev_t e0, e1, e2;
  int  idx, bp_bad, hs2;
  bit  ok;

  initial begin
    mem[mkey(11'h001, 11'h001)] = 32'hDEADBEEF;
    mem[mkey(11'h002, 11'h002)] = 32'hAABBCCDD;
    mem[mkey(11'h001, 11'h000)] = 32'h1111_0000;
    mem[mkey(11'h001, 11'h002)] = 32'h1111_0008;
    mem[mkey(11'h003, 11'h000)] = 32'h3333_0000;
    mem[mkey(11'h003, 11'h001)] = 32'h3333_0004;
    mem[mkey(11'h003, 11'h002)] = 32'h3333_0008;
    mem[mkey(11'h010, 11'h000)] = 32'h1010_0000;

    #1 rst = 1'b0;
    #2;
    chk("rst_pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h7F);
    chk("rst_a", DRAM_A, 0);
    chk("rst_d", DRAM_D, 0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h3F);

    // Read after reset: row empty in both builds.
    issue(1'b0, 32'h0000_1004, 32'h0, 4'h0);
    wait_rsp();
    e0 = ev_at(ev_base);
    e1 = ev_at(ev_base + 1);
    chk("b_act", e0.kind, K_ACT);
    chk("b_act_a", e0.a, 11'h001);
    chk("b_rd", e1.kind, K_RD);
    chk("b_rd_a", e1.a, 11'h001);
    chk("b_trcd", e1.cyc - e0.cyc, T_RCD + 1);
    chk("b_lat", rsp_cyc - hs_cyc, LAT_RD_EMPTY);
    chk("b_data", got_rdata, 32'hDEADBEEF);
    wait_idle();
    chk("b_nev", evq.size() - ev_base, OPEN ? 2 : 3);
    e2 = ev_at(evq.size() - 1);
    chk("b_tail", e2.kind, OPEN ? K_RD : K_PRE);
    chk("b_tail_wen", e2.wen, OPEN ? 4'hF : 4'h0);

    // Byte write to row 2.
    issue(1'b1, 32'h0000_2008, 32'h11223344, 4'b0100);
    wait_rsp();
    idx = ev_base + (OPEN ? 2 : 1);
    e0 = ev_at(idx - 1);
    e1 = ev_at(idx);
    chk("c_act", e0.kind, K_ACT);
    chk("c_act_a", e0.a, 11'h002);
    chk("c_wr", e1.kind, K_WR);
    chk("c_wr_a", e1.a, 11'h002);
    chk("c_wr_wen", e1.wen, 4'b1011);
    chk("c_wr_d", e1.d, 32'h11223344);
    chk("c_twr", rsp_cyc - e1.cyc, T_WR + 1);
    chk("c_lat", rsp_cyc - hs_cyc, OPEN ? LAT_WR_MISS : LAT_WR_EMPTY);
    chk("c_mem", mem[mkey(11'h002, 11'h002)], 32'hAA22CCDD);

    // Write with no byte enables: full sequence, nothing changes.
    issue(1'b1, 32'h0000_2008, 32'hFFFFFFFF, 4'h0);
    wait_rsp();
    chk("d_lat", rsp_cyc - hs_cyc, OPEN ? LAT_WR_HIT : LAT_WR_EMPTY);
    chk("d_mem", mem[mkey(11'h002, 11'h002)], 32'hAA22CCDD);
    chk("d_rdata_hold", got_rdata, 32'hDEADBEEF);
    chk("d_rdata_after", rsp_rdata, 32'hDEADBEEF);

    issue(1'b0, 32'h0000_2008, 32'h0, 4'h0);
    wait_rsp();
    chk("e_data", got_rdata, 32'hAA22CCDD);
    chk("e_lat", rsp_cyc - hs_cyc, OPEN ? LAT_RD_HIT : LAT_RD_EMPTY);

    // Same-row pair.
    issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    wait_rsp();
    chk("f1_data", got_rdata, 32'h1111_0000);
    chk("f1_lat", rsp_cyc - hs_cyc, OPEN ? LAT_RD_MISS : LAT_RD_EMPTY);
    issue(1'b0, 32'h0000_1008, 32'h0, 4'h0);
    wait_rsp();
    e0 = ev_at(ev_base + (OPEN ? 0 : 1));
    chk("f2_nev", evq.size() - ev_base, OPEN ? 1 : 2);
    chk("f2_rd", e0.kind, K_RD);
    chk("f2_rd_a", e0.a, 11'h002);
    chk("f2_data", got_rdata, 32'h1111_0008);
    chk("f2_lat", rsp_cyc - hs_cyc, OPEN ? LAT_RD_HIT : LAT_RD_EMPTY);

    // Row change: precharge, tRP, activate row 3.
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    wait_rsp();
    idx = OPEN ? ev_base : ev_base - 1;
    e0 = ev_at(idx);
    e1 = ev_at(idx + 1);
    e2 = ev_at(idx + 2);
    chk("g_pre", e0.kind, K_PRE);
    chk("g_act", e1.kind, K_ACT);
    chk("g_act_a", e1.a, 11'h003);
    chk("g_trp", e1.cyc - e0.cyc, OPEN ? T_RP + 1 : T_RP + 2);
    chk("g_rd", e2.kind, K_RD);
    chk("g_rd_a", e2.a, 11'h000);
    chk("g_data", got_rdata, 32'h3333_0000);
    chk("g_lat", rsp_cyc - hs_cyc, OPEN ? LAT_RD_MISS : LAT_RD_EMPTY);

    // Back-pressure: a second request held while the first runs.
    issue(1'b0, 32'h0000_3004, 32'h0, 4'h0);
    req_addr = 32'h0000_3008;
    req_valid = 1'b1;
    ok = 1'b0;
    bp_bad = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
      else if (req_ready) bp_bad++;
    end
    chk("h_rsp_timeout", ok, 1'b1);
    rsp_cyc = cyc;
    chk("h_ready_low", bp_bad, 0);
    chk("h_ready_at_rsp", req_ready, 1'b0);
    chk("h_data1", rsp_rdata, 32'h3333_0004);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    chk("h_hs_timeout", ok, 1'b1);
    hs2 = cyc;
    chk("h_accept_gap", hs2 - rsp_cyc, OPEN ? 1 : T_RP + 2);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp();
    chk("h_data2", got_rdata, 32'h3333_0008);
    chk("h_lat2", rsp_cyc - hs2, OPEN ? LAT_RD_HIT : LAT_RD_EMPTY);

    // Reset during the activate wait.
    issue(1'b0, 32'h0000_2008, 32'h0, 4'h0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ev_at(evq.size() - 1).kind == K_ACT && evq.size() > ev_base)
        ok = 1'b1;
    end
    chk("i_act_timeout", ok, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("i_rst_pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 7'h7F);
    chk("i_rst_a", DRAM_A, 0);
    chk("i_rst_ready", req_ready, 1'b1);
    chk("i_rst_rsp", rsp_valid, 1'b0);
    chk("i_rst_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 32'h0001_0000, 32'h0, 4'h0);
    wait_rsp();
    e0 = ev_at(ev_base);
    e1 = ev_at(ev_base + 1);
    chk("i_act", e0.kind, K_ACT);
    chk("i_act_a", e0.a, 11'h010);
    chk("i_rd_a", e1.a, 11'h000);
    chk("i_data", got_rdata, 32'h1010_0000);
    chk("i_lat", rsp_cyc - hs_cyc, LAT_RD_EMPTY);

    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_ctrl.md
# dram_ctrl

Single-port DRAM controller between the chip-internal memory slave (the AXI DRAM wrapper) and the off-chip DRAM pins of `top`. It accepts one word-sized read or write request at a time. It converts each request into the row-activate / column / precharge pin sequence expected by the DRAM model and returns read data on `DRAM_VALID`. Row-hit optimisation is optional at compile time.

## Interface
Parameters:
- `T_RP` – 5 – idle cycles after a precharge before an activate may issue.
- `T_RCD` – 5 – idle cycles after an activate before a column command may issue.
- `T_WR` – 5 – idle cycles after a write column command before the next command.

Ports:
- `clk` in 1 – system clock; one clock only.
- `rst` in 1 – reset, asynchronous, active-low.
- `req_valid` in 1 – request present.
- `req_ready` out 1 – request accepted when high together with `req_valid`.
- `req_write` in 1 – 1 = write, 0 = read.
- `req_addr` in 32 – byte address; bits [22:2] are used.
- `req_wdata` in 32 – write data.
- `req_wstrb` in 4 – byte enables, 1 = write that byte.
- `rsp_valid` out 1 – one-cycle pulse: read data valid, or write done.
- `rsp_rdata` out 32 – read data, valid with `rsp_valid` on reads.
- `DRAM_CSn` out 1 – chip select, active-low.
- `DRAM_RASn` out 1 – row strobe, active-low.
- `DRAM_CASn` out 1 – column strobe, active-low.
- `DRAM_WEn` out 4 – per-byte write enable, active-low.
- `DRAM_A` out 11 – multiplexed row/column address.
- `DRAM_D` out 32 – write data.
- `DRAM_Q` in 32 – read data.
- `DRAM_VALID` in 1 – `DRAM_Q` valid.

## Operation
- Address map: row = `req_addr[22:12]` (11 b); col = `req_addr[11:2]` zero-extended to 11 b.
- Pin commands (all registered, each held exactly one cycle, `DRAM_CSn`=0 during a command):
  - ACT: RASn=0, CASn=1, WEn=4'hF, A=row.
  - READ: RASn=1, CASn=0, WEn=4'hF, A=col.
  - WRITE: RASn=1, CASn=0, WEn=~wstrb, A=col, D=wdata.
  - PRE: RASn=0, CASn=1, WEn=4'h0.
- Idle pin state: CSn=0, RASn=1, CASn=1, WEn=4'hF, A=0, D=0.
- FSM states: IDLE, PRE, ACT, COL, RDWAIT, WRWAIT, DONE.
  - IDLE: `req_ready`=1. On handshake, latch write/addr/wdata/wstrb. Go to ACT if no row is open, COL on a row hit, PRE on a row miss.
  - PRE: issue PRE, clear the open-row flag, wait `T_RP` cycles, go to ACT.
  - ACT: issue ACT, record the open row, wait `T_RCD` cycles, go to COL.
  - COL: issue READ or WRITE. Reads go to RDWAIT; writes go to WRWAIT.
  - RDWAIT: on `DRAM_VALID`=1, capture `DRAM_Q` into `rsp_rdata` and go to DONE. No timeout.
  - WRWAIT: wait `T_WR` cycles, go to DONE.
  - DONE: `rsp_valid`=1 for one cycle, then go to IDLE. In close-page mode, DONE goes to PRE first, and the response is still pulsed in DONE.
- Delay counter: 3 bits, loaded with parameter−1 on entry to the wait; the state advances when the counter reaches 0. Parameters 1..8 are legal; 0 is illegal.
- `req_wstrb`=4'h0 on a write: still runs the full sequence with WEn=4'hF, and `rsp_valid` still pulses.
- `DRAM_VALID` outside RDWAIT is ignored.

## Timing
- Reset values:
  - FSM: IDLE, open-row flag cleared.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0.
  - Pins: CSn=1, RASn=1, CASn=1, WEn=4'hF, A=0, D=0.
- Reset asserted mid-sequence aborts immediately. Pins return to reset values, with no precharge issued. The first access after reset always issues ACT.
- `req_ready` is high only in IDLE. There is no request queue, and at most one request is outstanding.
- Read latency, handshake to `rsp_valid`:
  - Row empty: 1 + `T_RCD` + 1 + L_dram + 1 cycles.
  - Row miss: adds `T_RP` + 1.
  - Row hit: 2 + L_dram, where L_dram is the cycle count from READ to `DRAM_VALID`.
- `rsp_valid` is never asserted in the same cycle as `req_ready`.

## Configuration
- `DRAM_OPEN_PAGE_EN` defined (open page):
  - The row stays open after an access.
  - Same row → COL directly.
  - Different row → PRE, then ACT.
- `DRAM_OPEN_PAGE_EN` undefined (close page):
  - Every access ends with PRE plus `T_RP` before IDLE.
  - Every access starts with ACT.
  - There is no hit path, and the open-row register is removed.

## Structure
- Shared package `dram_pkg`:
  - State enum `dram_state_t`.
  - Command pin constants (IDLE/ACT/READ/WRITE/PRE encodings).
  - Row/column field widths.
- Sub-module `dram_delay_cnt`: loadable down-counter with a `done` output, instantiated once for tRP/tRCD/tWR.

## Test plan
- Reset mid-ACT wait: assert `rst`=0 → pins at reset values within the same cycle; the next read to 0x0001_0000 issues ACT with A=0x010.
- Read after reset, addr 0x0000_1004, DRAM word 0xDEADBEEF: ACT A=0x001, then READ A=0x001 `T_RCD` cycles later → `rsp_rdata`=0xDEADBEEF with a one-cycle `rsp_valid`.
- Byte write addr 0x0000_2008, wdata 0x11223344, wstrb 4'b0100 → WRITE WEn=4'b1011, A=0x002; only byte 2 changes to 0x22; `rsp_valid` after `T_WR`+1.
- Open-page hit (`DRAM_OPEN_PAGE_EN`): read 0x1000 then 0x1008 → second access has no ACT/PRE, READ A=0x002, latency 2+L_dram.
- Row miss: read 0x1000 then 0x3000 → PRE, `T_RP` wait, ACT A=0x003, READ A=0x000; close-page build shows PRE after every access.
- Back-pressure: hold `req_valid`=1 with new addr during RDWAIT → `req_ready` stays 0 until DONE has passed; the request is accepted on return to IDLE.
